ibex_wb_arbiter: RTL and testbench



---
 rtl/ibex_wb_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_ibex_wb_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_wb_arbiter.sv
// ibex_wb_arbiter: merges EX results and load responses onto a single
// registered register-file write port. EX results that cannot be written
// immediately wait in a small in-order FIFO, and both operand read ports
// are forwarded from the FIFO and the write-port register so that readers
// always see the newest pending value of a register.
module ibex_wb_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [DataWidth-1:0] rf_rdata_a_i,
  input  logic [DataWidth-1:0] rf_rdata_b_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic                 fifo_full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [PtrW:0]   DepthIdx = (PtrW + 1)'(Depth);

  // FIFO storage holds effective addresses, so no re-masking is needed later.
  logic [4:0]           fifo_addr_r [Depth];
  logic [DataWidth-1:0] fifo_data_r [Depth];
  logic [PtrW-1:0]      head_r;
  logic [PtrW-1:0]      tail_r;
  logic [CntW-1:0]      count_r;

  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic [4:0]           lsu_eff_s;
  logic [4:0]           ex_eff_s;
  logic                 lsu_sel_s;
  logic                 pop_s;
  logic                 ex_acc_s;
  logic                 ex_live_s;
  logic                 bypass_s;
  logic                 push_s;
  logic                 wr_we_s;
  logic [4:0]           wr_addr_s;
  logic [DataWidth-1:0] wr_data_s;

  // With 16 architectural registers the top address bit carries no meaning.
  function automatic logic [4:0] eff_addr(input logic [4:0] addr);
    logic [4:0] res;
    if (RV32E) begin
      res = {1'b0, addr[3:0]};
    end else begin
      res = addr;
    end
    return res;
  endfunction

  // Pointer increment with wrap at Depth (Depth need not be a power of two).
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    logic [PtrW-1:0] res;
    if (ptr == LastPtr) begin
      res = {PtrW{1'b0}};
    end else begin
      res = ptr + PtrW'(1);
    end
    return res;
  endfunction

  // Newest-first operand forwarding: FIFO (walked oldest to newest so the
  // newest match wins), then the write-port register, then raw RF data.
  function automatic logic [DataWidth-1:0] fwd_data(input logic [4:0]           raddr,
                                                     input logic [DataWidth-1:0] raw);
    logic [4:0]           addr;
    logic [DataWidth-1:0] res;
    logic [PtrW:0]        idx;
    addr = eff_addr(raddr);
    res  = raw;
    if (rf_we_o && (rf_waddr_o == addr)) begin
      res = rf_wdata_o;
    end else begin
      res = raw;
    end
    for (int i = 0; i < Depth; i++) begin
      idx = {1'b0, head_r} + (PtrW + 1)'(i);
      if (idx >= DepthIdx) begin
        idx = idx - DepthIdx;
      end else begin
        idx = idx;
      end
      if ((CntW'(i) < count_r) && (fifo_addr_r[idx[PtrW-1:0]] == addr)) begin
        res = fifo_data_r[idx[PtrW-1:0]];
      end else begin
        res = res;
      end
    end
    if (addr == 5'd0) begin
      res = raw;
    end else begin
      res = res;
    end
    return res;
  endfunction

  // Handshake and routing decisions for this cycle.
  always_comb begin
    lsu_eff_s    = eff_addr(lsu_waddr_i);
    ex_eff_s     = eff_addr(ex_waddr_i);
    fifo_empty_s = (count_r == {CntW{1'b0}});
    fifo_full_s  = (count_r == DepthCnt);
    lsu_sel_s    = lsu_valid_i && (lsu_eff_s != 5'd0);
    pop_s        = !fifo_empty_s && !lsu_sel_s;
    ex_ready_o   = !fifo_full_s || pop_s;
    ex_acc_s     = ex_valid_i && ex_ready_o;
    ex_live_s    = ex_acc_s && (ex_eff_s != 5'd0);
    bypass_s     = ex_live_s && fifo_empty_s && !lsu_sel_s;
    push_s       = ex_live_s && !bypass_s;
  end

  // Strict-priority write-port select: load, then FIFO head, then bypass.
  always_comb begin
    wr_we_s   = 1'b0;
    wr_addr_s = 5'd0;
    wr_data_s = {DataWidth{1'b0}};
    if (lsu_sel_s) begin
      wr_we_s   = 1'b1;
      wr_addr_s = lsu_eff_s;
      wr_data_s = lsu_wdata_i;
    end else if (pop_s) begin
      wr_we_s   = 1'b1;
      wr_addr_s = fifo_addr_r[head_r];
      wr_data_s = fifo_data_r[head_r];
    end else if (bypass_s) begin
      wr_we_s   = 1'b1;
      wr_addr_s = ex_eff_s;
      wr_data_s = ex_wdata_i;
    end else begin
      wr_we_s   = 1'b0;
      wr_addr_s = 5'd0;
      wr_data_s = {DataWidth{1'b0}};
    end
  end

  // FIFO storage, pointers and saturating occupancy counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_r  <= {PtrW{1'b0}};
      tail_r  <= {PtrW{1'b0}};
      count_r <= {CntW{1'b0}};
      for (int i = 0; i < Depth; i++) begin
        fifo_addr_r[i] <= 5'd0;
        fifo_data_r[i] <= {DataWidth{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_addr_r[tail_r] <= ex_eff_s;
        fifo_data_r[tail_r] <= ex_wdata_i;
        tail_r              <= next_ptr(tail_r);
      end
      if (pop_s) begin
        head_r <= next_ptr(head_r);
      end
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r != DepthCnt) begin
            count_r <= count_r + CntW'(1);
          end
        end
        2'b01: begin
          if (count_r != {CntW{1'b0}}) begin
            count_r <= count_r - CntW'(1);
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Registered register-file write port (one cycle after selection).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= 5'd0;
      rf_wdata_o <= {DataWidth{1'b0}};
    end else begin
      rf_we_o    <= wr_we_s;
      rf_waddr_o <= wr_addr_s;
      rf_wdata_o <= wr_data_s;
    end
  end

  // Operand forwarding for both read ports.
  always_comb begin
    rdata_a_o = fwd_data(raddr_a_i, rf_rdata_a_i);
    rdata_b_o = fwd_data(raddr_b_i, rf_rdata_b_i);
  end

  assign fifo_full_o = fifo_full_s;

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Self-checking bench for ibex_wb_arbiter: directed scenarios followed by
// random traffic, compared against a queue-based write-back model.
module tb_ibex_wb_arbiter;

  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_valid;
  logic [4:0]    ex_waddr;
  logic [DW-1:0] ex_wdata;
  logic          lsu_valid;
  logic [4:0]    lsu_waddr;
  logic [DW-1:0] lsu_wdata;
  logic [4:0]    raddr_a, raddr_b;
  logic [DW-1:0] rf_rdata_a, rf_rdata_b;

  logic          ex_ready, rf_we, fifo_full;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata, rdata_a, rdata_b;

  logic          e_ex_ready, e_rf_we, e_fifo_full;
  logic [4:0]    e_rf_waddr;
  logic [DW-1:0] e_rf_wdata, e_rdata_a, e_rdata_b;

  ibex_wb_arbiter #(.DataWidth(DW), .RV32E(1'b0), .Depth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b), .fifo_full_o(fifo_full)
  );

  ibex_wb_arbiter #(.DataWidth(DW), .RV32E(1'b1), .Depth(DEPTH)) dut_e (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_valid_i(ex_valid), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(e_ex_ready),
    .lsu_valid_i(lsu_valid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b),
    .rf_rdata_a_i(rf_rdata_a), .rf_rdata_b_i(rf_rdata_b),
    .rdata_a_o(e_rdata_a), .rdata_b_o(e_rdata_b), .fifo_full_o(e_fifo_full)
  );

  always #5 clk = ~clk;

  // Reference model: pending EX results in order, plus the write port.
  typedef struct {
    logic [4:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           q[$];
  logic          m_we;
  logic [4:0]    m_waddr;
  logic [DW-1:0] m_wdata;
  logic          last_acc;
  logic          last_ready_obs;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input logic [4:0] a);
    bit hit = 1'b0;
    foreach (q[i]) if (q[i].a == a) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [4:0] a, input logic [DW-1:0] raw);
    if (a == 5'd0) return raw;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].a == a) return q[i].d;
    if (m_we && m_waddr == a) return m_wdata;
    return raw;
  endfunction

  task automatic model_clear();
    q.delete();
    m_we    = 1'b0;
    m_waddr = 5'd0;
    m_wdata = '0;
  endtask

  task automatic set_idle();
    ex_valid  = 1'b0; ex_waddr  = 5'd0; ex_wdata  = '0;
    lsu_valid = 1'b0; lsu_waddr = 5'd0; lsu_wdata = '0;
  endtask

  // One clock: check everything before the edge, then advance the model.
  task automatic tick();
    logic exp_ready;
    logic legal;
    logic acc;
    logic byp;
    wr_t  w;
    rf_rdata_a = $urandom;
    rf_rdata_b = $urandom;
    @(negedge clk);
    exp_ready = (q.size() < DEPTH) || (q.size() > 0 && !lsu_valid);
    legal = !(lsu_valid && in_q(lsu_waddr));
    chk("lsu_hazard", {31'd0, legal}, 32'd1);
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    if (m_we) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
      chk("rf_wdata", rf_wdata, m_wdata);
    end
    chk("ex_ready", {31'd0, ex_ready}, {31'd0, exp_ready});
    chk("fifo_full", {31'd0, fifo_full}, {31'd0, (q.size() == DEPTH)});
    chk("rdata_a", rdata_a, fwd(raddr_a, rf_rdata_a));
    chk("rdata_b", rdata_b, fwd(raddr_b, rf_rdata_b));
    last_ready_obs = ex_ready;
    @(posedge clk);
    acc      = ex_valid && exp_ready;
    last_acc = acc;
    byp      = 1'b0;
    if (lsu_valid) begin
      m_we = 1'b1; m_waddr = lsu_waddr; m_wdata = lsu_wdata;
    end else if (q.size() > 0) begin
      w = q.pop_front();
      m_we = 1'b1; m_waddr = w.a; m_wdata = w.d;
    end else if (acc && ex_waddr != 5'd0) begin
      m_we = 1'b1; m_waddr = ex_waddr; m_wdata = ex_wdata; byp = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (acc && ex_waddr != 5'd0 && !byp) begin
      w.a = ex_waddr; w.d = ex_wdata;
      q.push_back(w);
    end
    #1;
  endtask

  logic [4:0] written[$];
  logic [4:0] ex_list[3];
  logic [4:0] exp_order[7];
  logic [4:0] cand;
  int         idx;

  initial begin
    set_idle();
    raddr_a = 5'd7; raddr_b = 5'd3;
    rf_rdata_a = 32'h1234_5678; rf_rdata_b = 32'h9ABC_DEF0;
    rst_n = 1'b0;
    model_clear();
    #2;
    // Reset state
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_full", {31'd0, fifo_full}, 32'd0);
    chk("rst_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_rdata_a", rdata_a, 32'h1234_5678);
    chk("rst_rdata_b", rdata_b, 32'h9ABC_DEF0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // EX-only write, one cycle latency
    ex_valid = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hA5A5_0001;
    tick();
    chk("ex_only_ready", {31'd0, last_ready_obs}, 32'd1);
    chk("ex_only_we", {31'd0, rf_we}, 32'd1);
    chk("ex_only_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("ex_only_wdata", rf_wdata, 32'hA5A5_0001);
    set_idle();
    tick();

    // Collision: load first, EX result one cycle later, forwarded meanwhile
    raddr_a = 5'd7;
    lsu_valid = 1'b1; lsu_waddr = 5'd3; lsu_wdata = 32'h0000_1111;
    ex_valid  = 1'b1; ex_waddr  = 5'd7; ex_wdata  = 32'h0000_2222;
    tick();
    set_idle();
    chk("coll_first_waddr", {27'd0, rf_waddr}, 32'd3);
    chk("coll_first_wdata", rf_wdata, 32'h0000_1111);
    chk("coll_fwd_a", rdata_a, 32'h0000_2222);
    tick();
    chk("coll_second_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("coll_second_wdata", rf_wdata, 32'h0000_2222);
    chk("coll_fwd_a2", rdata_a, 32'h0000_2222);
    tick();

    // Backpressure while a load stream holds the port
    ex_list = '{5'd1, 5'd2, 5'd4};
    exp_order = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd1, 5'd2, 5'd4};
    written.delete();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      lsu_valid = (c < 4);
      lsu_waddr = 5'(10 + c);
      lsu_wdata = 32'hB000_0000 + 32'(c);
      ex_valid  = (idx < 3);
      ex_waddr  = (idx < 3) ? ex_list[idx] : 5'd0;
      ex_wdata  = 32'hE000_0000 | {27'd0, ex_waddr};
      tick();
      if (last_acc) idx++;
      if (rf_we) written.push_back(rf_waddr);
      if (c == 1) chk("bp_full", {31'd0, fifo_full}, 32'd1);
      if (c == 2) chk("bp_ready_low", {31'd0, last_ready_obs}, 32'd0);
    end
    set_idle();
    chk("bp_all_accepted", 32'(idx), 32'd3);
    chk("bp_write_count", 32'(written.size()), 32'd7);
    for (int i = 0; i < 7 && i < written.size(); i++)
      chk("bp_order", {27'd0, written[i]}, {27'd0, exp_order[i]});

    // x0 write discarded; address 0 reads raw data
    raddr_a = 5'd0;
    ex_valid = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hFFFF_FFFF;
    tick();
    set_idle();
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    chk("x0_rdata_a", rdata_a, rf_rdata_a);
    tick();
    chk("x0_we2", {31'd0, rf_we}, 32'd0);

    // RV32E address folding on the second instance
    raddr_b = 5'd3;
    ex_valid = 1'b1; ex_waddr = 5'h13; ex_wdata = 32'h3333_0013;
    tick();
    set_idle();
    chk("e_we", {31'd0, e_rf_we}, 32'd1);
    chk("e_waddr", {27'd0, e_rf_waddr}, 32'd3);
    chk("e_wdata", e_rf_wdata, 32'h3333_0013);
    chk("e_fwd_b", e_rdata_b, 32'h3333_0013);
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ex_valid = ($urandom_range(0, 99) < 60);
      ex_waddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ex_wdata = $urandom;
      lsu_valid = ($urandom_range(0, 99) < 35);
      cand = 5'($urandom_range(1, 31));
      for (int t = 0; t < 8 && in_q(cand); t++) cand = 5'($urandom_range(1, 31));
      if (in_q(cand)) lsu_valid = 1'b0;
      lsu_waddr = cand;
      lsu_wdata = $urandom;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) raddr_a = q[$urandom_range(0, q.size() - 1)].a;
      else if ($urandom_range(0, 1) == 1) raddr_a = m_waddr;
      else raddr_a = 5'($urandom_range(0, 7));
      if (q.size() > 0 && $urandom_range(0, 1) == 1) raddr_b = q[q.size() - 1].a;
      else raddr_b = 5'($urandom_range(0, 7));
      tick();
    end
    set_idle();
    for (int i = 0; i < 4; i++) tick();

    // Reset with two queued entries
    lsu_valid = 1'b1; lsu_waddr = 5'd20; lsu_wdata = 32'h0000_0020;
    ex_valid  = 1'b1; ex_waddr  = 5'd21; ex_wdata  = 32'h0000_0021;
    tick();
    lsu_waddr = 5'd22; lsu_wdata = 32'h0000_0022;
    ex_waddr  = 5'd23; ex_wdata  = 32'h0000_0023;
    tick();
    set_idle();
    chk("pre_rst_full", {31'd0, fifo_full}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("mid_rst_wdata", rf_wdata, 32'd0);
    chk("mid_rst_full", {31'd0, fifo_full}, 32'd0);
    chk("mid_rst_ready", {31'd0, ex_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_we", {31'd0, rf_we}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
